// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding, product codes and change width for the dispenser
package vend_pkg;

    localparam int CHG_W = 3;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_VEND, S_GAP, S_PAY1, S_PAY05, S_DONE, S_ERR
    } state_t;

    localparam logic [1:0] PROD_NONE  = 2'b00;
    localparam logic [1:0] PROD_WATER = 2'b01;
    localparam logic [1:0] PROD_COKE  = 2'b10;
    localparam logic [1:0] PROD_BAD   = 2'b11;

endpackage

// File: rtl/vend_dispenser_pulse_timer.sv
// rtl/vend_dispenser_pulse_timer.sv - loadable down-counter timing pulse and gap phases
module pulse_timer #(
    parameter int W = 3
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         start,
    input  logic [W-1:0] len,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Loading len-1 makes expire land on the last cycle of a len-cycle phase.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            cnt <= '0;
        else if (start)
            cnt <= len - W'(1);
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/vend_dispenser.sv
// rtl/vend_dispenser.sv - motor and coin-eject sequencer with exact-change inventory check
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_LEN     = 4,
    parameter int GAP_LEN       = 2,
    parameter int INV_W         = 8,
    parameter int INV_INIT_ONE  = 20,
    parameter int INV_INIT_HALF = 20
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Vld,
    output logic             Rdy,
    input  logic [1:0]       Prod,
    input  logic [CHG_W-1:0] Chg,
    input  logic             Refill,
    output logic             MotorWater,
    output logic             MotorCoke,
    output logic             Eject1,
    output logic             Eject05,
    output logic             Done,
    output logic             Err,
    output logic [INV_W-1:0] Cnt1,
    output logic [INV_W-1:0] Cnt05
);

    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int TW      = $clog2(MAX_LEN + 1);

    state_t           state;
    logic [1:0]       prod_q;
    logic [CHG_W-1:0] chg_q, n1_left, n05_left;
    logic [CHG_W-1:0] plan_n1, plan_n05, coin_n1, coin_n05;
    logic             bad;
    logic             t_start, t_expire;
    logic [TW-1:0]    t_len;

    assign Rdy = (state == S_IDLE) && !Refill;

    // Pay as many 1 TL coins as stock allows; the rest must come from 0.5 TL coins.
    always_comb begin
        plan_n1 = chg_q >> 1;
        if (INV_W'(plan_n1) > Cnt1)
            plan_n1 = CHG_W'(Cnt1);
        plan_n05 = chg_q - (plan_n1 << 1);
        bad      = (prod_q == PROD_BAD) || (INV_W'(plan_n05) > Cnt05);
        coin_n1  = (state == S_CHECK) ? plan_n1  : n1_left;
        coin_n05 = (state == S_CHECK) ? plan_n05 : n05_left;
    end

    always_comb begin
        t_start = 1'b0;
        t_len   = TW'(PULSE_LEN);
        case (state)
            S_CHECK: t_start = 1'b1;
            S_VEND, S_PAY1, S_PAY05: begin
                t_start = t_expire;
                t_len   = TW'(GAP_LEN);
            end
            S_GAP: t_start = t_expire;
            default: t_start = 1'b0;
        endcase
    end

    pulse_timer #(.W(TW)) u_timer (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .start  (t_start),
        .len    (t_len),
        .expire (t_expire)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= S_IDLE;
            prod_q     <= PROD_NONE;
            chg_q      <= '0;
            n1_left    <= '0;
            n05_left   <= '0;
            MotorWater <= 1'b0;
            MotorCoke  <= 1'b0;
            Eject1     <= 1'b0;
            Eject05    <= 1'b0;
            Done       <= 1'b0;
            Err        <= 1'b0;
            Cnt1       <= INV_W'(INV_INIT_ONE);
            Cnt05      <= INV_W'(INV_INIT_HALF);
        end else begin
            case (state)
                S_IDLE: begin
                    if (Refill) begin
                        Cnt1  <= INV_W'(INV_INIT_ONE);
                        Cnt05 <= INV_W'(INV_INIT_HALF);
                    end else if (Vld) begin
                        prod_q <= Prod;
                        chg_q  <= Chg;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK, S_GAP: begin
                    if (state == S_CHECK && bad) begin
                        Err   <= 1'b1;
                        state <= S_ERR;
                    end else if (state == S_CHECK && prod_q != PROD_NONE) begin
                        MotorWater <= (prod_q == PROD_WATER);
                        MotorCoke  <= (prod_q == PROD_COKE);
                        n1_left    <= plan_n1;
                        n05_left   <= plan_n05;
                        state      <= S_VEND;
                    end else if (state == S_CHECK || t_expire) begin
                        // 1 TL coins always go out before any 0.5 TL coin.
                        if (coin_n1 != '0) begin
                            Eject1   <= 1'b1;
                            Cnt1     <= Cnt1 - 1'b1;
                            n1_left  <= coin_n1 - 1'b1;
                            n05_left <= coin_n05;
                            state    <= S_PAY1;
                        end else if (coin_n05 != '0) begin
                            Eject05  <= 1'b1;
                            Cnt05    <= Cnt05 - 1'b1;
                            n1_left  <= '0;
                            n05_left <= coin_n05 - 1'b1;
                            state    <= S_PAY05;
                        end else begin
                            Done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_VEND, S_PAY1, S_PAY05: begin
                    if (t_expire) begin
                        MotorWater <= 1'b0;
                        MotorCoke  <= 1'b0;
                        Eject1     <= 1'b0;
                        Eject05    <= 1'b0;
                        state      <= S_GAP;
                    end
                end
                default: begin
                    Done  <= 1'b0;
                    Err   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_dispenser.sv
// tb/tb_vend_dispenser.sv - scoreboard bench for vend_dispenser with an arithmetic inventory model
module tb_vend_dispenser;

    localparam int P     = 4;
    localparam int G     = 2;
    localparam int INIT1 = 20;
    localparam int INIT5 = 20;

    logic       Clk, Rst_n, Vld, Rdy, Refill;
    logic [1:0] Prod;
    logic [2:0] Chg;
    logic       MotorWater, MotorCoke, Eject1, Eject05, Done, Err;
    logic [7:0] Cnt1, Cnt05;

    vend_dispenser dut (
        .Clk(Clk), .Rst_n(Rst_n), .Vld(Vld), .Rdy(Rdy), .Prod(Prod), .Chg(Chg),
        .Refill(Refill), .MotorWater(MotorWater), .MotorCoke(MotorCoke),
        .Eject1(Eject1), .Eject05(Eject05), .Done(Done), .Err(Err),
        .Cnt1(Cnt1), .Cnt05(Cnt05)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int err; int water; int coke; int e1; int e05; int lat; int first; int c1; int c05;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_pass = 0;
    int   inv1 = INIT1, inv05 = INIT5;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Reference: greedy 1 TL payout limited by stock, remainder in 0.5 TL coins.
    function automatic exp_t plan(input int p, input int c);
        exp_t e;
        int n1, n05, k;
        n1 = c / 2;
        if (n1 > inv1) n1 = inv1;
        n05 = c - 2 * n1;
        e = '{default: 0};
        if (p == 3 || n05 > inv05) begin
            e.err = 1;
            e.lat = 2;
        end else begin
            k       = (p != 0 ? 1 : 0) + n1 + n05;
            e.water = (p == 1) ? P : 0;
            e.coke  = (p == 2) ? P : 0;
            e.e1    = n1 * P;
            e.e05   = n05 * P;
            e.lat   = 2 + k * (P + G);
            e.first = (k > 0) ? 2 : 0;
            inv1    = inv1 - n1;
            inv05   = inv05 - n05;
        end
        e.c1  = inv1;
        e.c05 = inv05;
        return e;
    endfunction

    // Monitor: tallies drive activity per order and checks it when Done/Err appears.
    int cyc = 0, acc_cyc = 0, first_off = 0;
    int t_w, t_c, t_e1, t_e05, mutex_bad, order_bad, seen05;
    bit busy = 0;

    always @(negedge Clk) begin
        exp_t e;
        if (!Rst_n) begin
            busy = 0;
        end else begin
            cyc++;
            if (busy) begin
                t_w   += int'(MotorWater);
                t_c   += int'(MotorCoke);
                t_e1  += int'(Eject1);
                t_e05 += int'(Eject05);
                if (int'(MotorWater) + int'(MotorCoke) + int'(Eject1) + int'(Eject05) > 1) mutex_bad = 1;
                if (Eject05) seen05 = 1;
                if (Eject1 && seen05 != 0) order_bad = 1;
                if ((MotorWater || MotorCoke || Eject1 || Eject05) && first_off == 0)
                    first_off = cyc - acc_cyc;
                if (Done || Err) begin
                    if (exp_q.size() == 0) chk("unexpected_completion", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("err_flag", int'(Err), e.err);
                        chk("done_flag", int'(Done), 1 - e.err);
                        chk("latency", cyc - acc_cyc, e.lat);
                        chk("first_drive", first_off, e.first);
                        chk("water_cycles", t_w, e.water);
                        chk("coke_cycles", t_c, e.coke);
                        chk("eject1_cycles", t_e1, e.e1);
                        chk("eject05_cycles", t_e05, e.e05);
                        chk("cnt1", int'(Cnt1), e.c1);
                        chk("cnt05", int'(Cnt05), e.c05);
                        chk("mutex", mutex_bad, 0);
                        chk("coin_order", order_bad, 0);
                    end
                    busy = 0;
                end else if (cyc - acc_cyc > 400) begin
                    chk("order_timeout", 0, 1);
                    busy = 0;
                end
            end else if (Done || Err) begin
                chk("spurious_completion", 1, 0);
            end
            if (Vld && Rdy) begin
                busy = 1; acc_cyc = cyc; first_off = 0;
                t_w = 0; t_c = 0; t_e1 = 0; t_e05 = 0;
                mutex_bad = 0; order_bad = 0; seen05 = 0;
            end
        end
    end

    task automatic send(input int p, input int c, input bit track);
        int guard;
        exp_t e;
        if (track) e = plan(p, c);
        @(posedge Clk); #1;
        Vld = 1'b1; Prod = p[1:0]; Chg = c[2:0];
        guard = 0;
        @(negedge Clk);
        while (!Rdy && guard < 1000) begin
            @(negedge Clk);
            guard++;
        end
        if (guard >= 1000) chk("accept_timeout", 0, 1);
        if (track) exp_q.push_back(e);
        @(posedge Clk); #1;
        Vld = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 2000) begin
            @(posedge Clk);
            guard++;
        end
        if (guard >= 2000) begin
            chk("drain_timeout", 0, 1);
            exp_q.delete();
        end
        @(posedge Clk);
    endtask

    task automatic refill();
        drain();
        @(posedge Clk); #1;
        Refill = 1'b1;
        @(posedge Clk); #1;
        Refill = 1'b0;
        inv1 = INIT1; inv05 = INIT5;
        chk("refill_cnt1", int'(Cnt1), INIT1);
        chk("refill_cnt05", int'(Cnt05), INIT5);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        Rst_n = 1'b0; Vld = 1'b0; Refill = 1'b0; Prod = 2'b00; Chg = 3'd0;
        #12;
        chk("rst_drives", int'({MotorWater, MotorCoke, Eject1, Eject05, Done, Err}), 0);
        chk("rst_cnt1", int'(Cnt1), INIT1);
        chk("rst_cnt05", int'(Cnt05), INIT5);
        @(posedge Clk); #2;
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("rst_rdy", int'(Rdy), 1);

        send(1, 0, 1);
        send(2, 3, 1);
        drain();
        chk("coke_cnt1", int'(Cnt1), 19);
        chk("coke_cnt05", int'(Cnt05), 19);

        for (int i = 0; i < 19; i++) send(0, 2, 1);
        send(1, 2, 1);
        drain();
        chk("half_only_cnt1", int'(Cnt1), 0);
        chk("half_only_cnt05", int'(Cnt05), 17);

        refill();
        for (int i = 0; i < 18; i++) send(0, 1, 1);
        for (int i = 0; i < 19; i++) send(0, 2, 1);
        send(0, 5, 1);
        send(3, int'($urandom_range(0, 7)), 1);
        drain();
        chk("short_cnt1", int'(Cnt1), 1);
        chk("short_cnt05", int'(Cnt05), 2);

        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) refill();
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1);
        end
        drain();

        // Abort a coke vend with reset while the motor is running.
        refill();
        send(0, 3, 1);
        drain();
        @(posedge Clk); #1;
        Vld = 1'b1; Prod = 2'b10; Chg = 3'd3;
        @(posedge Clk); #1;
        Vld = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        chk("coke_before_rst", int'(MotorCoke), 1);
        Rst_n = 1'b0;
        #1;
        chk("coke_async_drop", int'(MotorCoke), 0);
        chk("rst_reload_cnt1", int'(Cnt1), INIT1);
        chk("rst_reload_cnt05", int'(Cnt05), INIT5);
        inv1 = INIT1; inv05 = INIT5;
        repeat (2) @(posedge Clk);
        #2;
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("rdy_after_rst", int'(Rdy), 1);

        // Refill together with Vld: order held off one cycle, then accepted.
        send(0, 3, 1);
        drain();
        @(posedge Clk); #1;
        Refill = 1'b1; Vld = 1'b1; Prod = 2'b01; Chg = 3'd1;
        @(negedge Clk);
        chk("rdy_during_refill", int'(Rdy), 0);
        @(posedge Clk); #1;
        Refill = 1'b0;
        chk("refill_vld_cnt1", int'(Cnt1), INIT1);
        chk("refill_vld_cnt05", int'(Cnt05), INIT5);
        inv1 = INIT1; inv05 = INIT5;
        e = plan(1, 1);
        exp_q.push_back(e);
        @(negedge Clk);
        chk("rdy_after_refill", int'(Rdy), 1);
        @(posedge Clk); #1;
        Vld = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
